// File: rtl/pattern_sequencer_if.sv
// Control and observation bundle between the step sequencer and its driver.
// The master drives rate/mode/step controls; the slave (sequencer) returns the
// step index, per-step/per-cycle strobes and the ping-pong direction for debug.
interface pattern_sequencer_if;
    logic       i_enable;
    logic [1:0] i_mode;
    logic [2:0] i_speed;
    logic       i_step;
    logic [2:0] o_count;
    logic       o_tick;
    logic       o_wrap;
    logic       dbg_dir;

    modport master (
        output i_enable, i_mode, i_speed, i_step,
        input  o_count, o_tick, o_wrap, dbg_dir
    );

    modport slave (
        input  i_enable, i_mode, i_speed, i_step,
        output o_count, o_tick, o_wrap, dbg_dir
    );
endinterface

// File: rtl/pattern_sequencer.sv
// 3-bit step sequencer: programmable-rate prescaler plus forward, reverse,
// ping-pong and hold ordering, with manual single-step while paused.
module pattern_sequencer #(
    parameter int BASE_DIV   = 1000,
    parameter int PRESCALE_W = 24
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pattern_sequencer_if.slave   bus
);
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    localparam logic [1:0] MODE_FWD  = 2'b00;
    localparam logic [1:0] MODE_REV  = 2'b01;
    localparam logic [1:0] MODE_PING = 2'b10;
    localparam logic [1:0] MODE_HOLD = 2'b11;

    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PRESCALE_W-1:0] period;
    logic [2:0]            count_q, count_d;
    logic                  tick_q, tick_d;
    logic                  wrap_q, wrap_d;
    logic                  step_q, step_d;
    dir_e                  dir_q, dir_d;
    dir_e                  eff_dir;
    logic                  run;
    logic                  rate_hit;
    logic                  step_req;
    logic                  adv;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            presc_q <= '0;
            count_q <= 3'd0;
            tick_q  <= 1'b0;
            wrap_q  <= 1'b0;
            step_q  <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            tick_q  <= tick_d;
            wrap_q  <= wrap_d;
            step_q  <= step_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        period   = PRESCALE_W'(BASE_DIV) << bus.i_speed;
        run      = bus.i_enable && (bus.i_mode != MODE_HOLD);
        // >= rather than == so a mid-count speed-up fires at once instead of wrapping
        rate_hit = run && (presc_q >= (period - PRESCALE_W'(1)));
        step_req = bus.i_step && !step_q && !bus.i_enable && (bus.i_mode != MODE_HOLD);
        adv      = rate_hit || step_req;

        presc_d = '0;
        if (run && !rate_hit) begin
            presc_d = presc_q + PRESCALE_W'(1);
        end

        step_d  = bus.i_step;
        count_d = count_q;
        dir_d   = dir_q;
        tick_d  = adv;
        wrap_d  = 1'b0;

        // Endpoints force the bounce; elsewhere the stored direction is kept
        if (count_q == 3'd0) begin
            eff_dir = DIR_UP;
        end else if (count_q == 3'd7) begin
            eff_dir = DIR_DOWN;
        end else begin
            eff_dir = dir_q;
        end

        if (adv) begin
            case (bus.i_mode)
                MODE_FWD: begin
                    count_d = count_q + 3'd1;
                    wrap_d  = (count_q == 3'd7);
                end
                MODE_REV: begin
                    count_d = count_q - 3'd1;
                    wrap_d  = (count_q == 3'd0);
                end
                MODE_PING: begin
                    dir_d = eff_dir;
                    if (eff_dir == DIR_UP) begin
                        count_d = count_q + 3'd1;
                    end else begin
                        count_d = count_q - 3'd1;
                        wrap_d  = (count_q == 3'd1);
                    end
                end
                default: begin
                    count_d = count_q;
                end
            endcase
        end
    end

    assign bus.o_count = count_q;
    assign bus.o_tick  = tick_q;
    assign bus.o_wrap  = wrap_q;
    assign bus.dbg_dir = dir_q;
endmodule

// File: tb/tb_pattern_sequencer.sv
// Bench for pattern_sequencer: directed scenarios then randomized segments,
// every cycle compared against a behavioural model of the stepping rules.
module tb_pattern_sequencer;
    localparam int BASE_DIV   = 4;
    localparam int PRESCALE_W = 24;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pattern_sequencer_if bus ();

    pattern_sequencer #(
        .BASE_DIV   (BASE_DIV),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: step position, bounce direction, elapsed run cycles
    int m_count;
    bit m_down;
    int m_wait;
    bit m_prev_step;
    bit m_tick;
    bit m_wrap;

    int obs_ticks;
    int obs_wraps;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit en, input int mode, input int speed,
                              input bit step);
        bit adv;
        adv = 1'b0;
        if (r) begin
            m_count     = 0;
            m_down      = 1'b0;
            m_wait      = 0;
            m_prev_step = 1'b0;
            m_tick      = 1'b0;
            m_wrap      = 1'b0;
            return;
        end
        if (en && mode != 3) begin
            m_wait++;
            if (m_wait >= (BASE_DIV << speed)) begin
                adv    = 1'b1;
                m_wait = 0;
            end
        end else begin
            m_wait = 0;
        end
        if (!en && mode != 3 && step && !m_prev_step) adv = 1'b1;
        m_prev_step = step;
        m_tick = adv;
        m_wrap = 1'b0;
        if (adv) begin
            case (mode)
                0: begin
                    m_wrap  = (m_count == 7);
                    m_count = (m_count + 1) % 8;
                end
                1: begin
                    m_wrap  = (m_count == 0);
                    m_count = (m_count + 7) % 8;
                end
                2: begin
                    if (m_count == 0) m_down = 1'b0;
                    else if (m_count == 7) m_down = 1'b1;
                    if (m_down) begin
                        m_wrap  = (m_count == 1);
                        m_count = m_count - 1;
                    end else begin
                        m_count = m_count + 1;
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic cycle(input bit r, input bit en, input int mode, input int speed,
                         input bit step);
        @(negedge clk);
        rst          = r;
        bus.i_enable = en;
        bus.i_mode   = 2'(mode);
        bus.i_speed  = 3'(speed);
        bus.i_step   = step;
        @(posedge clk);
        model_edge(r, en, mode, speed, step);
        #1;
        if (bus.o_tick === 1'b1) obs_ticks++;
        if (bus.o_wrap === 1'b1) obs_wraps++;
        check("count", 8'(bus.o_count), 8'(m_count));
        check("tick",  8'(bus.o_tick),  8'(m_tick));
        check("wrap",  8'(bus.o_wrap),  8'(m_wrap));
    endtask

    task automatic run_n(input int n, input bit en, input int mode, input int speed);
        for (int i = 0; i < n; i++) cycle(1'b0, en, mode, speed, 1'b0);
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        obs_ticks = 0;
        obs_wraps = 0;
    endtask

    initial begin
        bus.i_enable = 1'b0;
        bus.i_mode   = 2'b00;
        bus.i_speed  = 3'd0;
        bus.i_step   = 1'b0;
        obs_ticks    = 0;
        obs_wraps    = 0;

        // Reset state
        do_reset();
        check("rst_count", 8'(bus.o_count), 8'd0);
        check("rst_tick",  8'(bus.o_tick),  8'd0);
        check("rst_wrap",  8'(bus.o_wrap),  8'd0);
        check("rst_dir",   8'(bus.dbg_dir), 8'd0);

        // Forward, period 4: first step on the 4th edge after enable
        run_n(3, 1'b1, 0, 0);
        check("fwd_first_wait", 8'(obs_ticks), 8'd0);
        run_n(1, 1'b1, 0, 0);
        check("fwd_first_step", 8'(bus.o_count), 8'd1);
        run_n(32, 1'b1, 0, 0);
        check("fwd_ticks", 8'(obs_ticks), 8'd9);
        check("fwd_wraps", 8'(obs_wraps), 8'd1);

        // Reverse, period 8
        do_reset();
        run_n(8, 1'b1, 1, 1);
        check("rev_first", 8'(bus.o_count), 8'd7);
        check("rev_first_wrap", 8'(bus.o_wrap), 8'd1);
        run_n(56, 1'b1, 1, 1);
        check("rev_ticks", 8'(obs_ticks), 8'd8);
        check("rev_wraps", 8'(obs_wraps), 8'd1);
        check("rev_end", 8'(bus.o_count), 8'd0);

        // Ping-pong: 0..7,6..0,1,2 then retained-direction mode switches
        do_reset();
        run_n(64, 1'b1, 2, 0);
        check("pp_pos", 8'(bus.o_count), 8'd2);
        check("pp_wraps", 8'(obs_wraps), 8'd1);
        run_n(28, 1'b1, 2, 0);
        check("pp_at5", 8'(bus.o_count), 8'd5);
        check("pp_dir_down", 8'(bus.dbg_dir), 8'd1);
        run_n(24, 1'b1, 0, 0);
        check("pp_fwd_at3", 8'(bus.o_count), 8'd3);
        check("pp_dir_kept", 8'(bus.dbg_dir), 8'd1);
        run_n(16, 1'b1, 2, 0);
        check("pp_resume", 8'(bus.o_count), 8'd1);
        check("pp_dir_up", 8'(bus.dbg_dir), 8'd0);

        // Paused manual stepping
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 0, 0, 1'b1);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 0, 0, 1'b1);
            cycle(1'b0, 1'b0, 0, 0, 1'b0);
        end
        check("man_ticks", 8'(obs_ticks), 8'd4);
        check("man_count", 8'(bus.o_count), 8'd4);
        obs_ticks = 0;
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 0, 0, 1'(i % 2));
        check("run_step_ignored", 8'(obs_ticks), 8'd2);

        // Speed drop mid-count, then hold
        do_reset();
        run_n(20, 1'b1, 0, 3);
        check("slow_no_tick", 8'(obs_ticks), 8'd0);
        run_n(1, 1'b1, 0, 0);
        check("speedup_tick", 8'(bus.o_tick), 8'd1);
        run_n(8, 1'b1, 0, 0);
        check("speedup_count", 8'(bus.o_count), 8'd3);
        obs_ticks = 0;
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 3, 0, 1'(i % 2));
        check("hold_ticks", 8'(obs_ticks), 8'd0);
        check("hold_count", 8'(bus.o_count), 8'd3);
        run_n(4, 1'b1, 0, 0);
        check("hold_exit", 8'(bus.o_count), 8'd4);

        // Reset mid-run with an advance due on that edge
        do_reset();
        run_n(23, 1'b1, 0, 0);
        check("pre_rst_count", 8'(bus.o_count), 8'd5);
        cycle(1'b1, 1'b1, 0, 0, 1'b0);
        check("midrst_count", 8'(bus.o_count), 8'd0);
        check("midrst_tick",  8'(bus.o_tick),  8'd0);
        check("midrst_wrap",  8'(bus.o_wrap),  8'd0);
        obs_ticks = 0;
        run_n(3, 1'b1, 0, 0);
        check("restart_wait", 8'(obs_ticks), 8'd0);
        run_n(1, 1'b1, 0, 0);
        check("restart_step", 8'(bus.o_count), 8'd1);

        // Randomized segments
        for (int seg = 0; seg < 150; seg++) begin
            int len, mode, speed;
            bit en;
            len   = $urandom_range(40, 1);
            mode  = $urandom_range(3, 0);
            speed = $urandom_range(3, 0);
            en    = ($urandom_range(3, 0) != 0);
            for (int i = 0; i < len; i++) begin
                cycle(($urandom_range(199, 0) == 0), en, mode, speed,
                      ($urandom_range(2, 0) == 0));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pattern_sequencer.md
Name: pattern_sequencer

Overview:
Step sequencer that drives the 3-bit step index into the seven-segment pattern decoder. It divides the system clock into a programmable step rate and advances a 3-bit count in forward, reverse or ping-pong order. It supports pause, hold and manual single-step, and emits per-step and per-cycle strobes for downstream effects logic.

Parameters:
BASE_DIV, 1000, clock cycles per step at i_speed=0; must be >=2.
PRESCALE_W, 24, prescaler width; BASE_DIV*128 must be < 2**PRESCALE_W.

Ports:
i_clk  input  1  system clock
i_rst  input  1  synchronous active-high reset
i_enable  input  1  1 = free-run at programmed rate; 0 = paused, single-step allowed
i_mode  input  2  00 forward wrap, 01 reverse wrap, 10 ping-pong, 11 hold
i_speed  input  3  rate select; step period = BASE_DIV << i_speed cycles
i_step  input  1  manual step request, level signal, rising-edge detected internally
o_count  output  3  current step index to pattern decoder
o_tick  output  1  one-cycle pulse, high in the same cycle o_count shows a new value
o_wrap  output  1  one-cycle pulse marking sequence-cycle completion

Behaviour:
- Single clock domain. All state updates on the rising edge of i_clk. i_rst is sampled synchronously only.
- Reset state: o_count=0, o_tick=0, o_wrap=0, prescaler=0, ping-pong direction register=up, step-edge register=0. Reset mid-run takes effect on the next edge and overrides all other activity.
- Prescaler:
  - Runs only when i_enable=1 and i_mode!=11. Otherwise it is held at 0.
  - period = BASE_DIV << i_speed, computed at PRESCALE_W bits.
  - rate_hit = (prescaler >= period-1). On rate_hit the prescaler clears to 0; otherwise it increments.
  - The >= compare means a speed decrease mid-count fires on the next cycle and never overflows.
- Step edge: step_req = i_step & ~i_step_q, where i_step_q is i_step registered. step_req advances the count only when i_enable=0 and i_mode!=11. It is ignored otherwise, with no queuing.
- Advance event:
  - adv = rate_hit (run) or step_req (paused). Both can never be true in the same cycle.
  - On adv, o_count updates at the next edge. o_tick=1 and o_wrap per the rules below are registered in that same cycle. Both are 0 in every cycle without a preceding adv.
  - Free-run latency: first advance occurs period cycles after i_enable rises.
- Next-count rules (3-bit arithmetic, modulo 8):
  - 00 forward: count+1. 7->0 sets o_wrap.
  - 01 reverse: count-1. 0->7 sets o_wrap.
  - 10 ping-pong:
    - Effective direction is up if count==0, down if count==7, else the direction register.
    - Next = count±1, and the direction register is loaded with the effective direction.
    - Resulting sequence: 0,1..7,6..1,0,1... o_wrap is set on the advance landing on 0 (from 1).
    - The direction register keeps its value when leaving and re-entering ping-pong.
  - 11 hold: no advance, prescaler held at 0, o_count frozen.
- Mode and speed changes apply immediately to the next adv. There is no prescaler reset on mode/speed change except when entering hold or disabling.
- Toggling i_enable 1->0 clears the prescaler. Re-enabling restarts a full period.

Test Plan:
- BASE_DIV=4, speed=0, mode=00, enable=1 after reset -> o_count 0,1,..,7,0 with a step every 4 cycles. First step 4 cycles after enable. o_tick pulses once per step. o_wrap=1 only on 7->0.
- Mode=01, speed=1 (period 8) -> o_count 0,7,6,..,0. o_wrap on 0->7 only. Ticks 8 cycles apart.
- Mode=10, speed=0 -> o_count 0..7,6..1,0,1,2. o_wrap only on the 1->0 advance. Switch to 00 at count 5, dir down, then back to 10 at count 3 -> continues per the retained register/endpoint rules.
- enable=0, i_step held high 5 cycles, then pulsed 3 more times -> exactly 4 advances, each with one o_tick. With enable=1, i_step pulses cause no extra advances.
- speed changed from 3 (period 32) to 0 while prescaler=20 -> advance on the next cycle, then 4-cycle spacing. Mode=11 -> o_count frozen, no o_tick, prescaler 0.
- Assert i_rst for 1 cycle mid-run at count 5 with o_tick pending -> next cycle o_count=0, o_tick=0, o_wrap=0. Restart timing is identical to the post-reset case.
